// File: rtl/pixel_sub_pkg.sv
// Shared constants and FSM state encoding for the chained pixel substitution stage.
package pixel_sub_pkg;

    localparam int unsigned SBOX_DEPTH = 256;
    localparam int unsigned SBOX_AW    = 8;
    localparam logic [7:0]  IV_DEFAULT = 8'h5A;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_substitute_sbox_ram.sv
// 256x8 S-box storage: one synchronous write port, one combinational read port, no reset.
module sbox_ram
    import pixel_sub_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [SBOX_AW-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [SBOX_AW-1:0] raddr,
    output logic [7:0]         rdata
);

    logic [7:0] mem [SBOX_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_substitute.sv
// Captures a 256-byte S-box, then encrypts pixels with chained substitution
// C[i] = S[P[i] ^ C[i-1]], seeded by IV at the start of every image.
module pixel_substitute
    import pixel_sub_pkg::*;
#(
    parameter int unsigned DEPTH = SBOX_DEPTH,
    parameter logic [7:0]  IV    = IV_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sbox_we,
    input  logic [7:0]       sbox_data,
    input  logic             sbox_done,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_data,
    input  logic             pix_last,
    output logic             enc_valid,
    input  logic             enc_ready,
    output logic [7:0]       enc_data,
    output logic             enc_last,
    output logic             table_ok,
    output logic             load_err,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [8:0] FULL = 9'(DEPTH);

    state_t     state, state_nxt;
    logic [8:0] wr_ptr, wr_ptr_nxt;
    logic       mem_we;
    logic [7:0] chain;
    logic [7:0] rd_addr;
    logic [7:0] sub_byte;
    logic       pix_xfer;

    sbox_ram u_sbox_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[SBOX_AW-1:0]),
        .wdata (sbox_data),
        .raddr (rd_addr),
        .rdata (sub_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD;
            wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
        end
    end

    // A write arriving in the same cycle as sbox_done counts toward the full table.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        mem_we     = 1'b0;
        case (state)
            LOAD: begin
                if (sbox_we) begin
                    if (wr_ptr == FULL) begin
                        state_nxt = ERR;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 9'd1;
                    end
                end
                if ((state_nxt == LOAD) && sbox_done) begin
                    state_nxt = (wr_ptr_nxt == FULL) ? RUN : ERR;
                end
            end
            default: begin
            end
        endcase
    end

    assign table_ok  = (state == RUN);
    assign load_err  = (state == ERR);
    assign pix_ready = (state == RUN) && (!enc_valid || enc_ready);
    assign pix_xfer  = pix_valid && pix_ready;
    assign rd_addr   = pix_data ^ chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain     <= IV;
            enc_valid <= 1'b0;
            enc_data  <= '0;
            enc_last  <= 1'b0;
            pix_count <= '0;
        end else if (pix_xfer) begin
            chain     <= pix_last ? IV : sub_byte;
            enc_valid <= 1'b1;
            enc_data  <= sub_byte;
            enc_last  <= pix_last;
            pix_count <= pix_last ? '0 : pix_count + 1'b1;
        end else if (enc_valid && enc_ready) begin
            enc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_substitute.sv
// Directed and randomized self-checking bench for pixel_substitute.
module tb_pixel_substitute;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sbox_we = 1'b0;
    logic [7:0]  sbox_data = '0;
    logic        sbox_done = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_data = '0;
    logic        pix_last = 1'b0;
    logic        enc_valid;
    logic        enc_ready = 1'b1;
    logic [7:0]  enc_data;
    logic        enc_last;
    logic        table_ok;
    logic        load_err;
    logic [15:0] pix_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [256];
    logic [7:0] rp [4096];
    logic       rl [4096];
    logic [7:0] re [4096];

    always #5 clk = ~clk;

    pixel_substitute #(.IV(8'h5A), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sbox_we   (sbox_we),
        .sbox_data (sbox_data),
        .sbox_done (sbox_done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .enc_valid (enc_valid),
        .enc_ready (enc_ready),
        .enc_data  (enc_data),
        .enc_last  (enc_last),
        .table_ok  (table_ok),
        .load_err  (load_err),
        .pix_count (pix_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sbox_we = 1'b0;
        sbox_done = 1'b0;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        enc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic load(input int n, input bit done);
        for (int i = 0; i < n; i++) begin
            sbox_we = 1'b1;
            sbox_data = sb[i % 256];
            @(posedge clk);
            #1;
        end
        sbox_we = 1'b0;
        if (done) begin
            sbox_done = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        int n = 0;
        pix_valid = 1'b1;
        pix_data = d;
        pix_last = last;
        @(negedge clk);
        while (!pix_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_rdy", 32'(pix_ready), 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int in_i, out_i, cyc;
        bit acc, drn;

        // 1: reset values, identity table, basic chaining
        do_reset();
        check("rst_table_ok", 32'(table_ok), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_enc_valid", 32'(enc_valid), 0);
        check("rst_enc_data", 32'(enc_data), 0);
        check("rst_pix_count", 32'(pix_count), 0);
        for (int i = 0; i < 256; i++) sb[i] = 8'(i);
        load(256, 1'b0);
        check("t1_not_ok_yet", 32'(table_ok), 0);
        sbox_done = 1'b1;
        @(posedge clk);
        #1;
        check("t1_table_ok", 32'(table_ok), 1);
        send(8'h00, 1'b0);
        check("t1_c0", 32'(enc_data), 32'h5A);
        check("t1_v0", 32'(enc_valid), 1);
        send(8'h01, 1'b0);
        check("t1_c1", 32'(enc_data), 32'h5B);
        check("t1_cnt", 32'(pix_count), 2);
        send(8'h02, 1'b1);
        check("t1_c2", 32'(enc_data), 32'h59);
        check("t1_last", 32'(enc_last), 1);
        check("t1_cnt_wrap", 32'(pix_count), 0);
        send(8'h10, 1'b0);
        check("t1_c3_iv", 32'(enc_data), 32'h4A);

        // 2: last pixel restores IV
        do_reset();
        load(256, 1'b1);
        send(8'h10, 1'b1);
        check("t2_c0", 32'(enc_data), 32'h4A);
        check("t2_last0", 32'(enc_last), 1);
        check("t2_cnt0", 32'(pix_count), 0);
        send(8'h10, 1'b0);
        check("t2_c1", 32'(enc_data), 32'h4A);
        check("t2_last1", 32'(enc_last), 0);
        check("t2_cnt1", 32'(pix_count), 1);

        // 3: inverted table, downstream stall
        do_reset();
        for (int i = 0; i < 256; i++) sb[i] = ~8'(i);
        load(256, 1'b1);
        enc_ready = 1'b0;
        send(8'h00, 1'b0);
        check("t3_c0", 32'(enc_data), 32'hA5);
        pix_valid = 1'b1;
        pix_data = 8'h01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_data", 32'(enc_data), 32'hA5);
            check("t3_hold_valid", 32'(enc_valid), 1);
            check("t3_hold_rdy", 32'(pix_ready), 0);
            @(posedge clk);
            #1;
        end
        enc_ready = 1'b1;
        @(negedge clk);
        check("t3_rel_rdy", 32'(pix_ready), 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("t3_c1", 32'(enc_data), 32'h5B);
        check("t3_cnt", 32'(pix_count), 2);
        @(posedge clk);
        #1;
        check("t3_drained", 32'(enc_valid), 0);

        // 4: short and long loads
        do_reset();
        load(255, 1'b0);
        check("t4_short_pre", 32'(load_err), 0);
        sbox_done = 1'b1;
        @(posedge clk);
        #1;
        check("t4_short_err", 32'(load_err), 1);
        check("t4_short_rdy", 32'(pix_ready), 0);
        check("t4_short_ok", 32'(table_ok), 0);
        do_reset();
        load(256, 1'b0);
        check("t4_full_noerr", 32'(load_err), 0);
        load(1, 1'b0);
        check("t4_long_err", 32'(load_err), 1);
        check("t4_long_ok", 32'(table_ok), 0);

        // 5: asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 256; i++) sb[i] = 8'(i);
        load(256, 1'b1);
        send(8'h33, 1'b0);
        pix_valid = 1'b1;
        pix_data = 8'h44;
        #2 rst = 1'b0;
        #1;
        check("t5_valid", 32'(enc_valid), 0);
        check("t5_data", 32'(enc_data), 0);
        check("t5_ok", 32'(table_ok), 0);
        check("t5_rdy", 32'(pix_ready), 0);
        check("t5_cnt", 32'(pix_count), 0);
        do_reset();
        load(256, 1'b1);
        send(8'h00, 1'b0);
        check("t5_restart", 32'(enc_data), 32'h5A);

        // 6: random table and image with random flow control
        do_reset();
        for (int i = 0; i < 256; i++) sb[i] = 8'($urandom);
        load(256, 1'b1);
        c = 8'h5A;
        for (int i = 0; i < 4096; i++) begin
            rp[i] = 8'($urandom);
            rl[i] = (i == 2047) || (i == 4095);
            c = sb[rp[i] ^ c];
            re[i] = c;
            if (rl[i]) c = 8'h5A;
        end
        in_i = 0;
        out_i = 0;
        cyc = 0;
        while (out_i < 4096 && cyc < 40000) begin
            pix_valid = (in_i < 4096) && ($urandom_range(0, 3) != 0);
            pix_data = (in_i < 4096) ? rp[in_i] : 8'h00;
            pix_last = (in_i < 4096) ? rl[in_i] : 1'b0;
            enc_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = pix_valid && pix_ready;
            drn = enc_valid && enc_ready;
            if (drn) begin
                check("rnd_data", 32'(enc_data), 32'(re[out_i]));
                check("rnd_last", 32'(enc_last), 32'(rl[out_i]));
                out_i++;
            end
            if (acc) in_i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        pix_valid = 1'b0;
        check("rnd_out_count", 32'(out_i), 4096);
        check("rnd_pix_count", 32'(pix_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
